// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot loader: default bus widths (also used by
// the CPU top and program memory) and the loader FSM state encoding.
package program_loader_pkg;

    // Default program memory address width; the largest image is 2**PL_ADD_WIDTH bytes.
    localparam int PL_ADD_WIDTH  = 7;
    // Default byte width of the load stream and of program memory write data.
    localparam int PL_DATA_WIDTH = 8;

    // Loader FSM states. The encoding is fixed so debug tooling can decode it.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_e;

endpackage

// File: rtl/program_loader.sv
// Byte-stream boot loader.
//
// A load begins with load_start. The loader then accepts a framed image:
// one length byte (image holds len+1 bytes), then the payload bytes, then
// an XOR checksum of the payload. Each payload byte is written to program
// memory one cycle after it is accepted. The CPU is held in reset until the
// whole image is written and the checksum matches.
//
// Handshake: a byte transfers on a rising clk edge where byte_valid and
// byte_ready are both 1. byte_ready is a registered output that is 1 exactly
// while the FSM is in LEN, DATA or CHK, so it never depends combinationally
// on byte_valid. A sender must hold byte_in/byte_valid stable until the
// transfer happens; a byte offered while byte_ready is 0 is not taken.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADD_WIDTH  = PL_ADD_WIDTH,
    parameter int DATA_WIDTH = PL_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [DATA_WIDTH-1:0] byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  pm_wr_en,
    output logic [ADD_WIDTH-1:0]  pm_addr,
    output logic [DATA_WIDTH-1:0] pm_wr_data,
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic                  load_err
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e                state_q,      state_d;
    logic [ADD_WIDTH-1:0]  len_q,        len_d;
    logic [ADD_WIDTH-1:0]  cnt_q,        cnt_d;
    logic [DATA_WIDTH-1:0] chk_q,        chk_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  pm_wr_en_q,   pm_wr_en_d;
    logic [ADD_WIDTH-1:0]  pm_addr_q,    pm_addr_d;
    logic [DATA_WIDTH-1:0] pm_wr_data_q, pm_wr_data_d;
    logic                  cpu_rst_q,    cpu_rst_d;
    logic                  load_done_q,  load_done_d;
    logic                  load_err_q,   load_err_d;

    // A byte is consumed this cycle.
    logic accept;

    // Handshake qualifier: only the registered ready gates acceptance.
    always_comb begin
        accept = byte_valid && byte_ready_q;
    end

    // Next-state and registered-output logic for the loader FSM.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        chk_d        = chk_q;
        pm_wr_en_d   = 1'b0;
        pm_addr_d    = pm_addr_q;
        pm_wr_data_d = pm_wr_data_q;
        cpu_rst_d    = cpu_rst_q;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                // A new load wipes the bookkeeping and puts the CPU back
                // in reset. Any byte offered in this cycle is not taken
                // because byte_ready is 0 in these states.
                if (load_start) begin
                    state_d     = LEN;
                    len_d       = '0;
                    cnt_d       = '0;
                    chk_d       = '0;
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                    cpu_rst_d   = 1'b1;
                end
            end

            LEN: begin
                // Length byte: image size is len+1, so upper bits beyond
                // the address width carry no information and are dropped.
                if (accept) begin
                    len_d   = byte_in[ADD_WIDTH-1:0];
                    state_d = DATA;
                end
            end

            DATA: begin
                if (accept) begin
                    pm_wr_en_d   = 1'b1;
                    pm_addr_d    = cnt_q;
                    pm_wr_data_d = byte_in;
                    chk_d        = chk_q ^ byte_in;
                    // The last payload byte lands at address len; the
                    // counter is parked there rather than wrapping.
                    if (cnt_q == len_q) begin
                        state_d = CHK;
                    end else begin
                        cnt_d = cnt_q + ADD_WIDTH'(1);
                    end
                end
            end

            CHK: begin
                if (accept) begin
                    if (byte_in == chk_q) begin
                        state_d     = DONE;
                        load_done_d = 1'b1;
                        cpu_rst_d   = 1'b0;
                    end else begin
                        state_d    = ERR;
                        load_err_d = 1'b1;
                        cpu_rst_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready follows the state we are about to enter, so it is already
        // high in the first cycle spent in LEN and drops with the exit
        // from CHK.
        byte_ready_d = (state_d == LEN) || (state_d == DATA) || (state_d == CHK);
    end

    // State register with asynchronous abort to reset values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            chk_q        <= '0;
            byte_ready_q <= 1'b0;
            pm_wr_en_q   <= 1'b0;
            pm_addr_q    <= '0;
            pm_wr_data_q <= '0;
            cpu_rst_q    <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            chk_q        <= chk_d;
            byte_ready_q <= byte_ready_d;
            pm_wr_en_q   <= pm_wr_en_d;
            pm_addr_q    <= pm_addr_d;
            pm_wr_data_q <= pm_wr_data_d;
            cpu_rst_q    <= cpu_rst_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    // All outputs come straight from flops.
    always_comb begin
        byte_ready = byte_ready_q;
        pm_wr_en   = pm_wr_en_q;
        pm_addr    = pm_addr_q;
        pm_wr_data = pm_wr_data_q;
        cpu_rst    = cpu_rst_q;
        load_done  = load_done_q;
        load_err   = load_err_q;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream boot loader that writes the CPU's byte-wide program memory through its write port (write enable, 7-bit address, 8-bit data).
- Receives a framed image over a valid/ready byte interface: length header, payload, then XOR checksum.
- Holds the CPU in reset until the whole image is written and the checksum matches.
- Sits between the chip input pins and the CPU top.

Parameters:
- ADD_WIDTH, 7, program memory address width; maximum image is 2^ADD_WIDTH bytes.
- DATA_WIDTH, 8, byte width of the stream and of program memory write data.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- load_start  in  1  one-cycle request to begin a new load
- byte_in  in  DATA_WIDTH  stream byte
- byte_valid  in  1  byte_in is valid this cycle
- byte_ready  out  1  loader accepts a byte this cycle
- pm_wr_en  out  1  program memory write enable
- pm_addr  out  ADD_WIDTH  program memory write address
- pm_wr_data  out  DATA_WIDTH  program memory write data
- cpu_rst  out  1  active-high reset to CPU core
- load_done  out  1  image loaded and checksum OK (level)
- load_err  out  1  checksum mismatch (level)

Behaviour:
- One clock domain (clk). rst is asynchronous and active-high. All outputs are registered.
- Reset values: byte_ready=0, pm_wr_en=0, pm_addr=0, pm_wr_data=0, cpu_rst=1, load_done=0, load_err=0. State is IDLE.
- A byte is accepted on a rising edge where byte_valid && byte_ready.
- FSM states: IDLE, LEN, DATA, CHK, DONE, ERR.
- IDLE / DONE / ERR, load_start=1:
  - Go to LEN.
  - Clear the address counter, length register, checksum accumulator, load_done and load_err.
  - Set cpu_rst=1.
- LEN: accepted byte is stored as len = byte_in[ADD_WIDTH-1:0]. The image holds len+1 bytes, range 1..128. Upper bits are ignored. Go to DATA.
- DATA, each accepted byte:
  - Next cycle: pm_wr_en=1, pm_addr=counter, pm_wr_data=byte_in, as a one-cycle pulse.
  - checksum ^= byte_in; counter increments.
  - When counter==len at acceptance, go to CHK. The counter does not wrap past len.
- CHK, accepted byte:
  - If byte_in == checksum: go to DONE, load_done=1 and cpu_rst=0 on the next cycle.
  - Otherwise: go to ERR, load_err=1, cpu_rst stays 1.
- byte_ready=1 exactly while in LEN, DATA or CHK, including the first cycle after entry. It is 0 in IDLE, DONE and ERR.
- Latency: memory write appears 1 cycle after byte acceptance. cpu_rst deasserts 1 cycle after checksum acceptance.
- Back-to-back bytes, one per cycle, are sustained with no bubbles.
- pm_wr_en is 0 in every cycle not following a DATA acceptance. pm_addr and pm_wr_data hold their last value when pm_wr_en=0.
- load_start in LEN, DATA or CHK is ignored; the load in progress continues.
- load_start together with byte_valid in the same cycle in IDLE/DONE/ERR: the byte is not accepted (byte_ready=0 that cycle).
- Reloading from DONE reasserts cpu_rst in the cycle after load_start. Memory contents beyond the new image are not cleared.
- rst during any state aborts immediately to reset values. A partial image may remain in memory, and the CPU stays in reset.
- byte_valid with byte_ready=0 is dropped; the sender must hold the byte until ready.

Decomposition:
- Shared package holds:
  - FSM state enum (3-bit encoding IDLE=0, LEN=1, DATA=2, CHK=3, DONE=4, ERR=5);
  - the ADD_WIDTH/DATA_WIDTH defaults, shared with the CPU top and program memory.
- Single module, no sub-modules. The XOR accumulator and address counter are inline registers.

Test Plan:
- Reset then idle: check rst=1 mid-cycle, then rst=0 with no stimulus. Required: cpu_rst=1, byte_ready=0, pm_wr_en=0, load_done=0, all persisting.
- Basic load: load_start, then stream 0x03, 0x13, 0x05, 0x10, 0x00, then checksum 0x06 back-to-back. Required:
  - four pm_wr_en pulses at addr 0..3 with data 13,05,10,00, each 1 cycle after acceptance;
  - load_done=1 and cpu_rst=0 one cycle after the checksum is accepted.
- Bad checksum: same image, checksum 0x07. Required: load_err=1, cpu_rst stays 1, load_done=0.
- Full size and gapped valid: length 0x7F, 128 bytes with random valid gaps, correct XOR. Required:
  - writes at addresses 0..127 in order;
  - no write during gaps;
  - load_done=1.
- Mid-load events:
  - load_start during DATA after 2 of 4 bytes: ignored, load completes normally.
  - Separate run: rst after 2 bytes. Immediate reset values and state IDLE; a subsequent full load succeeds.
- Reload: after DONE, load_start with a 1-byte image (0x00, 0xAA, checksum 0xAA). Required:
  - cpu_rst=1 the next cycle;
  - single write at addr 0 with data 0xAA;
  - load_done=1 and cpu_rst=0 again.
